mux_stream_arbiter: RTL
=======================

// Module: mux_stream_arbiter
// PURPOSE
//  Shares the 2-to-1 multiplexer datapath between two valid/ready requesters (A, B).
//  Selects one requester per cycle using sticky round-robin with a burst cap.
//  Drives the mux select and registers the winning word into a one-entry output stage.
//  Sits between two producer streams and a single downstream consumer.
// PARAMETERS
//  WIDTH      8  data width of a_data, b_data and y_data
//  MAX_BURST  4  maximum consecutive grants to one owner while the other requester
//                waits; legal range >=1; 1 gives strict alternation
// PORTS
//  clk          in   1      single clock; all state updates on rising edge
//  rst_n        in   1      reset, asynchronous assert, active-low
//  a_valid      in   1      requester A has a word
//  a_data       in   WIDTH  requester A word
//  a_ready      out  1      A word accepted this cycle (combinational)
//  b_valid      in   1      requester B has a word
//  b_data       in   WIDTH  requester B word
//  b_ready      out  1      B word accepted this cycle (combinational)
//  y_valid      out  1      output stage holds a word (registered)
//  y_data       out  WIDTH  output word (registered)
//  y_ready      in   1      downstream accepts y_data this cycle
//  select       out  1      current owner / mux select: 0 = A, 1 = B (registered)
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): y_valid=0, y_data=0, select=0, burst_cnt=0.
//    a_ready=b_ready=0 for as long as rst_n=0.
//  - load_en = !y_valid | y_ready. A grant is possible only when load_en=1.
//  - Grant rule, evaluated combinationally each cycle with load_en=1:
//    * neither valid: no grant; select holds; burst_cnt <= 0.
//    * only one valid: grant it.
//    * both valid: grant owner(select) if burst_cnt < MAX_BURST, else grant the other.
//  - On grant: the granted ready=1 and the other ready=0.
//    Next edge: y_data <= granted data, y_valid <= 1, select <= granted.
//    burst_cnt <= (granted==select) ? sat(burst_cnt+1) : 1.
//  - Counter width is $clog2(MAX_BURST+1). burst_cnt saturates at MAX_BURST.
//  - No grant while y_valid & y_ready: y_valid <= 0; y_data holds.
//  - load_en=0 (stalled): both readies 0; y_data, y_valid, select, burst_cnt hold.
//  - Latency: accepted word appears on y_data 1 cycle after its ready.
//    Full throughput of 1 word/cycle is sustained while y_ready=1.
//  - Simultaneous drain and load: the new word replaces the old in the same edge; no bubble.
//  - Owner drops valid mid-burst: the other requester is granted immediately if valid;
//    burst_cnt restarts at 1.
//  - Idle (no valid) clears burst_cnt but keeps the owner. The owner therefore wins
//    the first contested cycle after idle.
//  - Protocol: valid must not depend on ready. Data must be held stable while
//    valid=1 and ready=0. Both rules bind requesters; the block does not check them.
//  - Reset mid-transfer: a pending y word is dropped (y_valid=0 immediately).
//    Requester words not yet acknowledged are not consumed.
// TESTING
//  1 Hold rst_n=0, toggle clk -> y_valid=0, y_data=0, select=0, a_ready=b_ready=0.
//  2 Release reset; a_valid=1, a_data=8'hA5, b_valid=0, y_ready=1
//    -> a_ready=1 same cycle; next cycle y_valid=1, y_data=8'hA5, select=0.
//  3 a_valid=b_valid=1 continuously (A words 8'h10.., B words 8'h20..), y_ready=1,
//    MAX_BURST=4 -> y_data order A,A,A,B,B,B,B,A... (first A-run 3 after case 2 state,
//    else 4 from reset).
//  4 y_valid=1, y_ready=0 for 5 cycles with both valid
//    -> a_ready=b_ready=0; y_data, select, burst_cnt unchanged; resume on y_ready=1.
//  5 A owns with burst_cnt=2, then a_valid drops, b_valid=1
//    -> b_ready=1 that cycle; next edge select=1, burst_cnt=1, y_data=b_data.
//  6 Assert rst_n=0 between edges while y_valid=1
//    -> y_valid=0, select=0 without waiting for clk; no word lost from requesters.

Source files
------------

// File: rtl/mux_stream_arbiter.sv
// Two-requester valid/ready arbiter driving a 2:1 mux into a one-entry output stage.
// Sticky round-robin: the current owner keeps the grant until it has taken MAX_BURST words in a row while the other requester waits.
module mux_stream_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready,
    output logic             select
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] burst_cnt;
    logic             load_en;
    logic             grant;
    logic             gnt_sel;

    // Grant decision; readies are forced low while reset is asserted
    always_comb begin
        load_en = !y_valid || y_ready;
        grant   = 1'b0;
        gnt_sel = select;
        if (rst_n && load_en) begin
            if (a_valid && b_valid) begin
                grant   = 1'b1;
                gnt_sel = (burst_cnt < CNT_MAX) ? select : !select;
            end else if (a_valid) begin
                grant   = 1'b1;
                gnt_sel = 1'b0;
            end else if (b_valid) begin
                grant   = 1'b1;
                gnt_sel = 1'b1;
            end
        end
        a_ready = grant && !gnt_sel;
        b_ready = grant && gnt_sel;
    end

    // Output stage, owner and burst counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid   <= 1'b0;
            y_data    <= '0;
            select    <= 1'b0;
            burst_cnt <= '0;
        end else if (grant) begin
            y_valid <= 1'b1;
            y_data  <= gnt_sel ? b_data : a_data;
            select  <= gnt_sel;
            if (gnt_sel != select) begin
                burst_cnt <= CNT_ONE;
            end else if (burst_cnt != CNT_MAX) begin
                burst_cnt <= burst_cnt + CNT_ONE;
            end
        end else if (load_en) begin
            // Nobody valid: drain the stage, forget the run, keep the owner
            y_valid   <= 1'b0;
            burst_cnt <= '0;
        end
    end

endmodule
